// File: rtl/lane_note_scroller_if.sv
// Lane note scroller bus: sequencer/player controls in, note state and score events out.
interface lane_note_scroller_if #(
    parameter int SLOTS = 4,
    parameter int Y_W   = 8
);
    logic                 frame_tick;
    logic [1:0]           note_speed;
    logic                 spawn;
    logic                 spawn_ready;
    logic                 hit_press;
    logic [SLOTS-1:0]     note_valid;
    logic [SLOTS*Y_W-1:0] note_y;
    logic [1:0]           speed_latched;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic [7:0]           miss_count;

    modport master (
        output frame_tick, note_speed, spawn, hit_press,
        input  spawn_ready, note_valid, note_y, speed_latched, hit_pulse, miss_pulse, miss_count
    );

    modport slave (
        input  frame_tick, note_speed, spawn, hit_press,
        output spawn_ready, note_valid, note_y, speed_latched, hit_pulse, miss_pulse, miss_count
    );
endinterface

// File: rtl/lane_note_scroller.sv
// Per-lane falling-note engine: spawns notes at the top, moves them each frame,
// judges presses against the hit window and reports hits and misses.
module lane_note_scroller #(
    parameter int SLOTS   = 4,
    parameter int Y_W     = 8,
    parameter int STEP    = 2,
    parameter int Y_MAX   = 239,
    parameter int HIT_Y   = 200,
    parameter int HIT_WIN = 8
) (
    input logic                 clk,
    input logic                 resetn,
    lane_note_scroller_if.slave bus
);
    // Advance is done Y_W+3 bits wide so 3x speed can never wrap past Y_MAX.
    localparam int YW3 = Y_W + 3;
    // Window bounds kept as signed ints so HIT_WIN > HIT_Y cannot underflow.
    localparam int WLO = HIT_Y - HIT_WIN;
    localparam int WHI = HIT_Y + HIT_WIN;

    logic [SLOTS-1:0]          v_q, v_d;
    logic [SLOTS-1:0][Y_W-1:0] y_q, y_d;
    logic [SLOTS-1:0][YW3-1:0] y_adv;
    logic [SLOTS-1:0]          off, cand, hit_oh, hit_clr, spn_oh, miss_v;
    logic [1:0]                spd_q, spd_san;
    logic                      hit_q, miss_q, hit_any, taken;
    logic [Y_W-1:0]            best;
    logic [7:0]                mcnt_q;
    logic [3:0]                miss_n;
    logic [8:0]                msum;
    logic [YW3-1:0]            dy;

    assign spd_san = (bus.note_speed == 2'd0) ? 2'd1 : bus.note_speed;
    assign dy      = YW3'(spd_q) * YW3'(STEP);
    assign hit_clr = bus.hit_press ? hit_oh : '0;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        assign y_adv[g] = YW3'(y_q[g]) + dy;
        assign off[g]   = y_adv[g] > YW3'(Y_MAX);
        assign cand[g]  = v_q[g] && ($signed(32'(y_q[g])) >= WLO)
                                 && ($signed(32'(y_q[g])) <= WHI);
    end

    // Pick the hit candidate lowest on screen; strict compare keeps ties on the lowest index.
    always_comb begin
        hit_oh  = '0;
        hit_any = 1'b0;
        best    = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (cand[i] && (!hit_any || y_q[i] > best)) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit_any   = 1'b1;
                best      = y_q[i];
            end
        end
    end

    // Spawn target: lowest slot free at the start of the cycle.
    always_comb begin
        spn_oh = '0;
        taken  = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!v_q[i] && !taken) begin
                spn_oh[i] = bus.spawn;
                taken     = 1'b1;
            end
        end
    end

    // Slot next state: hit beats advance; spawn only lands in a slot that was already empty.
    always_comb begin
        v_d    = v_q;
        y_d    = y_q;
        miss_v = '0;
        miss_n = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (hit_clr[i]) begin
                v_d[i] = 1'b0;
                y_d[i] = '0;
            end else if (v_q[i] && bus.frame_tick) begin
                if (off[i]) begin
                    v_d[i]    = 1'b0;
                    y_d[i]    = '0;
                    miss_v[i] = 1'b1;
                end else begin
                    y_d[i] = y_adv[i][Y_W-1:0];
                end
            end else if (spn_oh[i]) begin
                v_d[i] = 1'b1;
                y_d[i] = '0;
            end
            miss_n = miss_n + {3'b000, miss_v[i]};
        end
        msum = {1'b0, mcnt_q} + {5'b00000, miss_n};
    end

    // State, speed latch and one-cycle score pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q    <= '0;
            y_q    <= '0;
            spd_q  <= 2'd1;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            mcnt_q <= '0;
        end else begin
            v_q    <= v_d;
            y_q    <= y_d;
            if (bus.frame_tick) spd_q <= spd_san;
            hit_q  <= bus.hit_press && hit_any;
            miss_q <= |miss_v;
            mcnt_q <= msum[8] ? 8'hFF : msum[7:0];
        end
    end

    assign bus.spawn_ready   = ~&v_q;
    assign bus.note_valid    = v_q;
    assign bus.note_y        = y_q;
    assign bus.speed_latched = spd_q;
    assign bus.hit_pulse     = hit_q;
    assign bus.miss_pulse    = miss_q;
    assign bus.miss_count    = mcnt_q;
endmodule

// File: tb/tb_lane_note_scroller.sv
// Bench for lane_note_scroller: expected values are queued as stimulus is driven
// and popped when the DUT output is sampled on the falling edge.
module tb_lane_note_scroller;
    logic        clk = 1'b0;
    logic        resetn;
    int          total = 0;
    int          bad = 0;
    logic [31:0] sb[$];
    logic [31:0] e;

    lane_note_scroller_if #(.SLOTS(4), .Y_W(8)) bus ();

    lane_note_scroller #(.SLOTS(4), .Y_W(8), .STEP(2), .Y_MAX(239), .HIT_Y(200), .HIT_WIN(8))
        dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_tick();
        bus.frame_tick = 1'b1; cyc();
        bus.frame_tick = 1'b0; cyc();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    task automatic do_spawn();
        bus.spawn = 1'b1; cyc();
        bus.spawn = 1'b0;
    endtask

    task automatic do_reset();
        bus.frame_tick = 1'b0; bus.spawn = 1'b0; bus.hit_press = 1'b0; bus.note_speed = 2'd1;
        resetn = 1'b0; cyc(); cyc();
        resetn = 1'b1; cyc();
    endtask

    task automatic test_reset();
        bus.frame_tick = 1'b0; bus.spawn = 1'b0; bus.hit_press = 1'b0; bus.note_speed = 2'd1;
        resetn = 1'b0;
        sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'd1); sb.push_back(32'd1); sb.push_back(32'h0);
        cyc(); cyc();
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL rst_valid got=%0h want=%0h", bus.note_valid, e); end
        e = sb.pop_front(); total++; if (bus.note_y !== e) begin bad++; $display("FAIL rst_y got=%0h want=%0h", bus.note_y, e); end
        e = sb.pop_front(); total++; if (32'(bus.speed_latched) !== e) begin bad++; $display("FAIL rst_speed got=%0d want=%0d", bus.speed_latched, e); end
        e = sb.pop_front(); total++; if (32'(bus.spawn_ready) !== e) begin bad++; $display("FAIL rst_ready got=%0d want=%0d", bus.spawn_ready, e); end
        e = sb.pop_front(); total++; if (32'({bus.hit_pulse, bus.miss_pulse, bus.miss_count}) !== e) begin bad++; $display("FAIL rst_score got=%0h want=%0h", {bus.hit_pulse, bus.miss_pulse, bus.miss_count}, e); end
        resetn = 1'b1; cyc();
    endtask

    task automatic test_advance();
        do_reset();
        do_spawn();
        sb.push_back(32'h1); sb.push_back(32'd20); sb.push_back(32'd1); sb.push_back(32'd1);
        ticks(10);
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL adv_valid got=%0h want=%0h", bus.note_valid, e); end
        e = sb.pop_front(); total++; if (32'(bus.note_y[7:0]) !== e) begin bad++; $display("FAIL adv_y got=%0d want=%0d", bus.note_y[7:0], e); end
        e = sb.pop_front(); total++; if (32'(bus.speed_latched) !== e) begin bad++; $display("FAIL adv_speed got=%0d want=%0d", bus.speed_latched, e); end
        e = sb.pop_front(); total++; if (32'(bus.spawn_ready) !== e) begin bad++; $display("FAIL adv_ready got=%0d want=%0d", bus.spawn_ready, e); end
        // back-to-back ticks on consecutive cycles
        sb.push_back(32'd24);
        bus.frame_tick = 1'b1; cyc(); cyc();
        bus.frame_tick = 1'b0; cyc();
        e = sb.pop_front(); total++; if (32'(bus.note_y[7:0]) !== e) begin bad++; $display("FAIL b2b_y got=%0d want=%0d", bus.note_y[7:0], e); end
    endtask

    task automatic test_fill();
        do_reset();
        sb.push_back(32'hF); sb.push_back(32'd0);
        bus.spawn = 1'b1; repeat (4) cyc();
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL fill_valid got=%0h want=%0h", bus.note_valid, e); end
        e = sb.pop_front(); total++; if (32'(bus.spawn_ready) !== e) begin bad++; $display("FAIL fill_ready got=%0d want=%0d", bus.spawn_ready, e); end
        sb.push_back(32'hF); sb.push_back(32'h0);
        cyc();
        bus.spawn = 1'b0;
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL fifth_valid got=%0h want=%0h", bus.note_valid, e); end
        e = sb.pop_front(); total++; if (bus.note_y !== e) begin bad++; $display("FAIL fifth_y got=%0h want=%0h", bus.note_y, e); end
    endtask

    task automatic test_miss();
        do_reset();
        do_spawn();
        ticks(116);
        bus.note_speed = 2'd3;
        sb.push_back(32'd234); sb.push_back(32'd3);
        do_tick();
        e = sb.pop_front(); total++; if (32'(bus.note_y[7:0]) !== e) begin bad++; $display("FAIL miss_pre_y got=%0d want=%0d", bus.note_y[7:0], e); end
        e = sb.pop_front(); total++; if (32'(bus.speed_latched) !== e) begin bad++; $display("FAIL miss_speed got=%0d want=%0d", bus.speed_latched, e); end
        sb.push_back(32'h0); sb.push_back(32'd1); sb.push_back(32'd1);
        bus.frame_tick = 1'b1; cyc();
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL miss_valid got=%0h want=%0h", bus.note_valid, e); end
        e = sb.pop_front(); total++; if (32'(bus.miss_pulse) !== e) begin bad++; $display("FAIL miss_pulse got=%0d want=%0d", bus.miss_pulse, e); end
        e = sb.pop_front(); total++; if (32'(bus.miss_count) !== e) begin bad++; $display("FAIL miss_count got=%0d want=%0d", bus.miss_count, e); end
        sb.push_back(32'd0); sb.push_back(32'd0);
        bus.frame_tick = 1'b0; cyc();
        e = sb.pop_front(); total++; if (32'(bus.miss_pulse) !== e) begin bad++; $display("FAIL miss_pulse_end got=%0d want=%0d", bus.miss_pulse, e); end
        e = sb.pop_front(); total++; if (bus.note_y !== e) begin bad++; $display("FAIL miss_y got=%0h want=%0h", bus.note_y, e); end
    endtask

    task automatic test_saturate();
        int n;
        do_reset();
        bus.note_speed = 2'd3;
        for (int r = 0; r < 64; r++) begin
            bus.spawn = 1'b1; repeat (4) cyc();
            bus.spawn = 1'b0;
            if (r == 0) sb.push_back(32'd4);
            if (r == 62) sb.push_back(32'd252);
            n = 0;
            while (bus.note_valid != 4'h0 && n < 60) begin
                do_tick(); n++;
            end
            if (n >= 60) begin
                total++; bad++;
                $display("FAIL sat_timeout round=%0d valid=%0h want=0", r, bus.note_valid);
                break;
            end
            if (r == 0 || r == 62) begin
                e = sb.pop_front(); total++; if (32'(bus.miss_count) !== e) begin bad++; $display("FAIL sat_count_r%0d got=%0d want=%0d", r, bus.miss_count, e); end
            end
        end
        sb.push_back(32'd255);
        e = sb.pop_front(); total++; if (32'(bus.miss_count) !== e) begin bad++; $display("FAIL sat_final got=%0d want=%0d", bus.miss_count, e); end
    endtask

    task automatic test_hit();
        do_reset();
        do_spawn();                 // A -> slot0
        ticks(94);                  // A=188, outside window
        sb.push_back(32'd0); sb.push_back(32'h1);
        bus.hit_press = 1'b1; cyc(); bus.hit_press = 1'b0;
        e = sb.pop_front(); total++; if (32'(bus.hit_pulse) !== e) begin bad++; $display("FAIL hit_early_pulse got=%0d want=%0d", bus.hit_pulse, e); end
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL hit_early_valid got=%0h want=%0h", bus.note_valid, e); end
        cyc();
        do_spawn();                 // B -> slot1
        ticks(2);                   // A=192 (low edge), B=4
        sb.push_back(32'd1); sb.push_back(32'h2);
        bus.hit_press = 1'b1; cyc(); bus.hit_press = 1'b0;
        e = sb.pop_front(); total++; if (32'(bus.hit_pulse) !== e) begin bad++; $display("FAIL hit_lo_pulse got=%0d want=%0d", bus.hit_pulse, e); end
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL hit_lo_valid got=%0h want=%0h", bus.note_valid, e); end
        sb.push_back(32'd0);
        cyc();
        e = sb.pop_front(); total++; if (32'(bus.hit_pulse) !== e) begin bad++; $display("FAIL hit_pulse_width got=%0d want=%0d", bus.hit_pulse, e); end
        do_spawn();                 // C -> slot0
        ticks(98);                  // B=200 (slot1), C=196 (slot0)
        sb.push_back(32'd1); sb.push_back(32'h1); sb.push_back(32'd196);
        bus.hit_press = 1'b1; cyc(); bus.hit_press = 1'b0;
        e = sb.pop_front(); total++; if (32'(bus.hit_pulse) !== e) begin bad++; $display("FAIL hit_big_pulse got=%0d want=%0d", bus.hit_pulse, e); end
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL hit_big_valid got=%0h want=%0h", bus.note_valid, e); end
        e = sb.pop_front(); total++; if (32'(bus.note_y[7:0]) !== e) begin bad++; $display("FAIL hit_keep_y got=%0d want=%0d", bus.note_y[7:0], e); end
        cyc();
        sb.push_back(32'd1); sb.push_back(32'h0);
        bus.hit_press = 1'b1; cyc(); bus.hit_press = 1'b0;
        e = sb.pop_front(); total++; if (32'(bus.hit_pulse) !== e) begin bad++; $display("FAIL hit2_pulse got=%0d want=%0d", bus.hit_pulse, e); end
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL hit2_valid got=%0h want=%0h", bus.note_valid, e); end
        cyc();
        sb.push_back(32'd0);
        bus.hit_press = 1'b1; cyc(); bus.hit_press = 1'b0;
        e = sb.pop_front(); total++; if (32'(bus.hit_pulse) !== e) begin bad++; $display("FAIL hit3_pulse got=%0d want=%0d", bus.hit_pulse, e); end
        cyc();
        do_spawn();                 // D -> slot0
        do_tick();                  // D=2
        do_spawn();                 // E -> slot1
        ticks(104);                 // D=210 (out), E=208 (high edge)
        sb.push_back(32'd1); sb.push_back(32'h1); sb.push_back(32'd210);
        bus.hit_press = 1'b1; cyc(); bus.hit_press = 1'b0;
        e = sb.pop_front(); total++; if (32'(bus.hit_pulse) !== e) begin bad++; $display("FAIL hit_hi_pulse got=%0d want=%0d", bus.hit_pulse, e); end
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL hit_hi_valid got=%0h want=%0h", bus.note_valid, e); end
        e = sb.pop_front(); total++; if (32'(bus.note_y[7:0]) !== e) begin bad++; $display("FAIL hit_out_y got=%0d want=%0d", bus.note_y[7:0], e); end
        cyc();
        sb.push_back(32'd0);
        bus.hit_press = 1'b1; cyc(); bus.hit_press = 1'b0;
        e = sb.pop_front(); total++; if (32'(bus.hit_pulse) !== e) begin bad++; $display("FAIL hit_out_pulse got=%0d want=%0d", bus.hit_pulse, e); end
    endtask

    task automatic test_speed_change();
        do_reset();
        do_spawn();
        ticks(50);                  // y=100
        bus.note_speed = 2'd2; cyc();
        sb.push_back(32'd102); sb.push_back(32'd2);
        do_tick();
        e = sb.pop_front(); total++; if (32'(bus.note_y[7:0]) !== e) begin bad++; $display("FAIL spd_y1 got=%0d want=%0d", bus.note_y[7:0], e); end
        e = sb.pop_front(); total++; if (32'(bus.speed_latched) !== e) begin bad++; $display("FAIL spd_latch2 got=%0d want=%0d", bus.speed_latched, e); end
        sb.push_back(32'd106);
        do_tick();
        e = sb.pop_front(); total++; if (32'(bus.note_y[7:0]) !== e) begin bad++; $display("FAIL spd_y2 got=%0d want=%0d", bus.note_y[7:0], e); end
        bus.note_speed = 2'd0;
        sb.push_back(32'd110); sb.push_back(32'd1); sb.push_back(32'd112);
        do_tick();
        e = sb.pop_front(); total++; if (32'(bus.note_y[7:0]) !== e) begin bad++; $display("FAIL spd0_y1 got=%0d want=%0d", bus.note_y[7:0], e); end
        e = sb.pop_front(); total++; if (32'(bus.speed_latched) !== e) begin bad++; $display("FAIL spd0_latch got=%0d want=%0d", bus.speed_latched, e); end
        do_tick();
        e = sb.pop_front(); total++; if (32'(bus.note_y[7:0]) !== e) begin bad++; $display("FAIL spd0_y2 got=%0d want=%0d", bus.note_y[7:0], e); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_spawn();                 // A -> slot0
        ticks(4);                   // A=8
        bus.spawn = 1'b1; repeat (3) cyc(); bus.spawn = 1'b0;   // slots 1..3 at 0
        ticks(96);                  // A=200, others 192
        bus.hit_press = 1'b1; cyc(); bus.hit_press = 1'b0; cyc();
        sb.push_back(32'hE);
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL combo_setup got=%0h want=%0h", bus.note_valid, e); end
        ticks(4);                   // slots 1..3 at 200, slot0 free
        sb.push_back(32'hD); sb.push_back(32'hCACA_0000); sb.push_back(32'd1); sb.push_back(32'd0);
        bus.frame_tick = 1'b1; bus.hit_press = 1'b1; bus.spawn = 1'b1; cyc();
        bus.frame_tick = 1'b0; bus.hit_press = 1'b0; bus.spawn = 1'b0;
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL combo_valid got=%0h want=%0h", bus.note_valid, e); end
        e = sb.pop_front(); total++; if (bus.note_y !== e) begin bad++; $display("FAIL combo_y got=%0h want=%0h", bus.note_y, e); end
        e = sb.pop_front(); total++; if (32'(bus.hit_pulse) !== e) begin bad++; $display("FAIL combo_hit got=%0d want=%0d", bus.hit_pulse, e); end
        e = sb.pop_front(); total++; if (32'(bus.miss_pulse) !== e) begin bad++; $display("FAIL combo_miss got=%0d want=%0d", bus.miss_pulse, e); end
        cyc();
        bus.note_speed = 2'd3;
        do_tick();                  // speed_latched becomes 3
        // reset asserted mid-cycle, away from any clock edge
        sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'd1); sb.push_back(32'h0);
        bus.frame_tick = 1'b1;
        #2 resetn = 1'b0;
        #1;
        e = sb.pop_front(); total++; if (32'(bus.note_valid) !== e) begin bad++; $display("FAIL arst_valid got=%0h want=%0h", bus.note_valid, e); end
        e = sb.pop_front(); total++; if (bus.note_y !== e) begin bad++; $display("FAIL arst_y got=%0h want=%0h", bus.note_y, e); end
        e = sb.pop_front(); total++; if (32'(bus.speed_latched) !== e) begin bad++; $display("FAIL arst_speed got=%0d want=%0d", bus.speed_latched, e); end
        e = sb.pop_front(); total++; if (32'({bus.hit_pulse, bus.miss_pulse, bus.miss_count}) !== e) begin bad++; $display("FAIL arst_score got=%0h want=%0h", {bus.hit_pulse, bus.miss_pulse, bus.miss_count}, e); end
        cyc();
        bus.frame_tick = 1'b0; resetn = 1'b1; cyc();
        do_spawn();
        sb.push_back(32'd2); sb.push_back(32'd3);
        do_tick();
        e = sb.pop_front(); total++; if (32'(bus.note_y[7:0]) !== e) begin bad++; $display("FAIL post_rst_y got=%0d want=%0d", bus.note_y[7:0], e); end
        e = sb.pop_front(); total++; if (32'(bus.speed_latched) !== e) begin bad++; $display("FAIL post_rst_speed got=%0d want=%0d", bus.speed_latched, e); end
    endtask

    initial begin
        resetn = 1'b0;
        bus.frame_tick = 1'b0; bus.spawn = 1'b0; bus.hit_press = 1'b0; bus.note_speed = 2'd1;
        cyc();
        test_reset();
        test_advance();
        test_fill();
        test_miss();
        test_saturate();
        test_hit();
        test_speed_change();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
